// File: rtl/fdtd_step_ctrl_if.sv
// fdtd_step_ctrl_if: run configuration, calc enables and field-memory strobes of the FDTD step sequencer.
interface fdtd_step_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int STEP_WIDTH = 16
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] grid_size;
    logic [STEP_WIDTH-1:0] n_steps;
    logic [ADDR_WIDTH-1:0] src_pos;
    logic                  calc_hy_en;
    logic                  calc_ez_en;
    logic                  calc_src_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_sel;
    logic                  busy;
    logic                  done;
    logic [STEP_WIDTH-1:0] step_cnt;

    modport master (
        output start, abort, grid_size, n_steps, src_pos,
        input  calc_hy_en, calc_ez_en, calc_src_en, rd_en, rd_addr,
               wr_en, wr_addr, wr_sel, busy, done, step_cnt
    );

    modport slave (
        input  start, abort, grid_size, n_steps, src_pos,
        output calc_hy_en, calc_ez_en, calc_src_en, rd_en, rd_addr,
               wr_en, wr_addr, wr_sel, busy, done, step_cnt
    );
endinterface

// File: rtl/fdtd_step_ctrl.sv
// fdtd_step_ctrl: 1D FDTD timestep sequencer issuing Hy, Ez and source updates with delayed write-back.
module fdtd_step_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int STEP_WIDTH = 16,
    parameter int CALC_LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fdtd_step_ctrl_if.slave  bus
);
    localparam int PW = ADDR_WIDTH + 2;
    localparam int DW = $clog2(CALC_LAT + 1);

    typedef enum logic [3:0] {IDLE, HY, HY_DRN, EZ, EZ_DRN, SRC, SRC_DRN, STEP_END, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] n_reg, src_reg, rd_addr;
    logic [STEP_WIDTH-1:0] steps_reg, step_cnt;
    logic [DW-1:0]         dcnt;
    logic                  hy_en, ez_en, src_en, busy, done, rd_en, drained, src_ok;
    logic [PW-1:0]         pipe [CALC_LAT];

    assign rd_en   = hy_en | ez_en | src_en;
    assign drained = dcnt == DW'(CALC_LAT);
    assign src_ok  = src_reg != '0 && src_reg < n_reg;

    assign bus.calc_hy_en  = hy_en;
    assign bus.calc_ez_en  = ez_en;
    assign bus.calc_src_en = src_en;
    assign bus.rd_en       = rd_en;
    assign bus.rd_addr     = rd_addr;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.step_cnt    = step_cnt;
    assign {bus.wr_en, bus.wr_sel, bus.wr_addr} = pipe[CALC_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_reg     <= '0;
            src_reg   <= '0;
            steps_reg <= '0;
            step_cnt  <= '0;
            rd_addr   <= '0;
            dcnt      <= '0;
            hy_en     <= 1'b0;
            ez_en     <= 1'b0;
            src_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int k = 0; k < CALC_LAT; k++) pipe[k] <= '0;
        end else begin
            hy_en   <= 1'b0;
            ez_en   <= 1'b0;
            src_en  <= 1'b0;
            done    <= 1'b0;
            dcnt    <= dcnt + DW'(1);
            pipe[0] <= {rd_en, ez_en | src_en, rd_addr};
            for (int k = 1; k < CALC_LAT; k++) pipe[k] <= pipe[k-1];
            // Abort also discards in-flight write-backs so nothing lands after the run is cancelled.
            if (bus.abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
                for (int k = 0; k < CALC_LAT; k++) pipe[k] <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        n_reg     <= bus.grid_size;
                        steps_reg <= bus.n_steps;
                        src_reg   <= bus.src_pos;
                        step_cnt  <= '0;
                        busy      <= 1'b1;
                        if (bus.grid_size < ADDR_WIDTH'(2) || bus.n_steps == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= HY;
                            hy_en   <= 1'b1;
                            rd_addr <= '0;
                        end
                    end
                    HY: if (rd_addr == n_reg - ADDR_WIDTH'(2)) begin
                        state <= HY_DRN;
                        dcnt  <= DW'(1);
                    end else begin
                        hy_en   <= 1'b1;
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    end
                    HY_DRN: if (drained) begin
                        state   <= EZ;
                        ez_en   <= 1'b1;
                        rd_addr <= ADDR_WIDTH'(1);
                    end
                    EZ: if (rd_addr == n_reg - ADDR_WIDTH'(1)) begin
                        state <= EZ_DRN;
                        dcnt  <= DW'(1);
                    end else begin
                        ez_en   <= 1'b1;
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    end
                    EZ_DRN: if (drained) begin
                        state   <= src_ok ? SRC : STEP_END;
                        src_en  <= src_ok;
                        rd_addr <= src_ok ? src_reg : rd_addr;
                    end
                    SRC: begin
                        state <= SRC_DRN;
                        dcnt  <= DW'(1);
                    end
                    SRC_DRN: if (drained) state <= STEP_END;
                    STEP_END: begin
                        step_cnt <= step_cnt + STEP_WIDTH'(1);
                        if (step_cnt + STEP_WIDTH'(1) == steps_reg) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= HY;
                            hy_en   <= 1'b1;
                            rd_addr <= '0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fdtd_step_ctrl.sv
// tb_fdtd_step_ctrl: directed checks of the FDTD step sequencer with CALC_LAT=2.
module tb_fdtd_step_ctrl;
    localparam int AW = 10;
    localparam int SW = 16;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fdtd_step_ctrl_if #(.ADDR_WIDTH(AW), .STEP_WIDTH(SW)) bus ();
    fdtd_step_ctrl #(.ADDR_WIDTH(AW), .STEP_WIDTH(SW), .CALC_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n, input int s, input int p);
        bus.grid_size = AW'(n);
        bus.n_steps   = SW'(s);
        bus.src_pos   = AW'(p);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Hand schedule for N=8, src=3: {hy,ez,src,addr} per cycle after the accepting edge.
    function automatic logic [AW+2:0] exp_rd(input int c);
        if (c >= 0 && c <= 6)  return {3'b100, AW'(c)};
        if (c >= 9 && c <= 15) return {3'b010, AW'(c - 8)};
        if (c == 18)           return {3'b001, AW'(3)};
        return '0;
    endfunction

    function automatic logic [AW+1:0] exp_wr(input int c);
        logic [AW+2:0] e;
        e = exp_rd(c - L);
        return (e[AW+2:AW] != 3'b000) ? {1'b1, e[AW+1] | e[AW], e[AW-1:0]} : '0;
    endfunction

    function automatic logic [AW+2:0] obs_rd();
        return {bus.calc_hy_en, bus.calc_ez_en, bus.calc_src_en, bus.rd_en ? bus.rd_addr : AW'(0)};
    endfunction

    function automatic logic [AW+1:0] obs_wr();
        return bus.wr_en ? {1'b1, bus.wr_sel, bus.wr_addr} : '0;
    endfunction

    initial begin
        int hy_n, ez_n, src_n, wr_n, done_n, done_at, multi, src_addr, busy_n;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.grid_size = '0;
        bus.n_steps = '0;
        bus.src_pos = '0;

        tick();
        tick();
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_rd_en", 32'(bus.rd_en), 0);
        check("reset_wr_en", 32'(bus.wr_en), 0);
        check("reset_step_cnt", 32'(bus.step_cnt), 0);
        rst_n = 1'b1;
        tick();

        // N=8, one step, source at 3: exact per-cycle schedule of reads and write-backs
        start_run(8, 1, 3);
        for (int c = 0; c <= 24; c++) begin
            check($sformatf("run1_rd_c%0d", c), 32'(obs_rd()), 32'(exp_rd(c)));
            check($sformatf("run1_wr_c%0d", c), 32'(obs_wr()), 32'(exp_wr(c)));
            check($sformatf("run1_done_c%0d", c), 32'(bus.done), 32'(c == 22));
            check($sformatf("run1_busy_c%0d", c), 32'(bus.busy), 32'(c <= 22));
            tick();
        end
        check("run1_step_cnt", 32'(bus.step_cnt), 1);

        // N=4, three steps, source out of range
        start_run(4, 3, 9);
        hy_n = 0; ez_n = 0; src_n = 0; wr_n = 0; done_n = 0; done_at = -1; multi = 0;
        for (int c = 0; c < 40; c++) begin
            hy_n  += int'(bus.calc_hy_en);
            ez_n  += int'(bus.calc_ez_en);
            src_n += int'(bus.calc_src_en);
            wr_n  += int'(bus.wr_en);
            multi += int'(int'(bus.calc_hy_en) + int'(bus.calc_ez_en) + int'(bus.calc_src_en) > 1);
            if (bus.done) begin
                done_n++;
                done_at = c;
            end
            tick();
        end
        check("run2_hy_count", 32'(hy_n), 9);
        check("run2_ez_count", 32'(ez_n), 9);
        check("run2_src_count", 32'(src_n), 0);
        check("run2_wr_count", 32'(wr_n), 18);
        check("run2_done_count", 32'(done_n), 1);
        check("run2_done_cycle", 32'(done_at), 33);
        check("run2_overlap", 32'(multi), 0);
        check("run2_step_cnt", 32'(bus.step_cnt), 3);

        // Degenerate runs: N=1, then n_steps=0
        start_run(1, 5, 0);
        check("n1_done", 32'(bus.done), 1);
        check("n1_busy", 32'(bus.busy), 1);
        check("n1_rd_en", 32'(bus.rd_en), 0);
        tick();
        check("n1_busy_after", 32'(bus.busy), 0);
        check("n1_done_after", 32'(bus.done), 0);
        check("n1_step_cnt", 32'(bus.step_cnt), 0);
        start_run(8, 0, 3);
        check("s0_done", 32'(bus.done), 1);
        check("s0_rd_en", 32'(bus.rd_en), 0);
        tick();
        check("s0_busy_after", 32'(bus.busy), 0);

        // Abort on the 3rd Ez cycle of step 2
        start_run(8, 3, 3);
        done_n = 0;
        for (int c = 0; c < 33; c++) begin
            done_n += int'(bus.done);
            tick();
        end
        check("abort_pre_ez", 32'(bus.calc_ez_en), 1);
        check("abort_pre_addr", 32'(bus.rd_addr), 3);
        check("abort_pre_step_cnt", 32'(bus.step_cnt), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_rd_en", 32'(bus.rd_en), 0);
        wr_n = 0; busy_n = 0;
        for (int c = 0; c < 8; c++) begin
            wr_n   += int'(bus.wr_en);
            done_n += int'(bus.done);
            busy_n += int'(bus.busy);
            tick();
        end
        check("abort_wr_after", 32'(wr_n), 0);
        check("abort_done", 32'(done_n), 0);
        check("abort_busy_after", 32'(busy_n), 0);
        check("abort_step_cnt", 32'(bus.step_cnt), 1);

        // Clean run after abort: N=4, src=2 gives a 14-cycle step
        start_run(4, 1, 2);
        src_n = 0; src_addr = -1; done_at = -1;
        for (int c = 0; c < 20; c++) begin
            if (bus.calc_src_en) begin
                src_n++;
                src_addr = int'(bus.rd_addr);
            end
            if (bus.done) done_at = c;
            tick();
        end
        check("post_src_count", 32'(src_n), 1);
        check("post_src_addr", 32'(src_addr), 2);
        check("post_done_cycle", 32'(done_at), 14);
        check("post_step_cnt", 32'(bus.step_cnt), 1);

        // Restart with a different grid size while busy is ignored
        start_run(8, 1, 3);
        hy_n = 0; ez_n = 0; done_at = -1;
        for (int c = 0; c < 26; c++) begin
            hy_n += int'(bus.calc_hy_en);
            ez_n += int'(bus.calc_ez_en);
            if (bus.done) done_at = c;
            bus.start = (c == 5);
            bus.grid_size = (c >= 5) ? AW'(4) : AW'(8);
            tick();
        end
        bus.start = 1'b0;
        check("restart_hy_count", 32'(hy_n), 7);
        check("restart_ez_count", 32'(ez_n), 7);
        check("restart_done_cycle", 32'(done_at), 22);

        // Asynchronous reset in the middle of the Hy phase
        start_run(8, 2, 3);
        tick();
        tick();
        tick();
        check("rst_pre_hy", 32'(bus.calc_hy_en), 1);
        rst_n = 1'b0;
        #1;
        check("rst_hy", 32'(bus.calc_hy_en), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_step_cnt", 32'(bus.step_cnt), 0);
        wr_n = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            wr_n += int'(bus.wr_en);
        end
        check("rst_wr_held", 32'(wr_n), 0);
        rst_n = 1'b1;
        tick();
        check("rst_release_busy", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
